// File: rtl/intr_source_ctrl.sv
// Fixed-priority interrupt source controller: latches four peripheral requests and
// serves them one at a time on the datapath interrupt interface. Optional: INTR_SRC_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request in service, waiting for a pending bit
// ISSUE | one-cycle intWrite strobe of the selected source
// WAIT  | holding the request until the datapath pulses intr
// DONE  | one-cycle devAck to the serviced source
module intr_source_ctrl #(
  parameter int DW = 16
`ifdef INTR_SRC_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [3:0]      devReq,
  input  logic [4*DW-1:0] devData,
  input  logic [3:0]      devMask,
  input  logic            intr,
  input  logic [DW-1:0]   intDataOut,
  output logic            int0,
  output logic            int1,
  output logic            int2,
  output logic            int3,
  output logic            intLvl1,
  output logic            intLvl0,
  output logic            intWrite,
  output logic [DW-1:0]   intDataIn,
  output logic [3:0]      devAck,
  output logic [DW-1:0]   devRespData,
  output logic            busy,
  output logic [15:0]     svcCount
`ifdef INTR_SRC_TIMEOUT_EN
  , output logic          timeoutFlag
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q;
  logic [3:0]    pending_q, pending_d;
  logic [DW-1:0] data_q [4];
  logic [1:0]    sel_q;
  logic [1:0]    pick;
  logic [3:0]    set_v, clr_v;
  logic [3:0]    int_q;
  logic [1:0]    lvl_q;
  logic          wr_q;
  logic [DW-1:0] din_q;
  logic [3:0]    ack_q;
  logic [DW-1:0] resp_q;
  logic          busy_q;
  logic [15:0]   svc_q;
`ifdef INTR_SRC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q;
  logic          tmo_q;
`endif

  // A new request in the ISSUE cycle beats the clear, so the source is served again.
  always_comb begin
    set_v     = devReq & devMask;
    clr_v     = (state_q == ISSUE) ? (4'b0001 << sel_q) : 4'b0000;
    pending_d = (pending_q & ~clr_v) | set_v;
  end

  always_comb begin
    pick = 2'd0;
    if (pending_q[3])      pick = 2'd3;
    else if (pending_q[2]) pick = 2'd2;
    else if (pending_q[1]) pick = 2'd1;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pending_q <= '0;
      for (int n = 0; n < 4; n++) data_q[n] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int n = 0; n < 4; n++)
        if (set_v[n]) data_q[n] <= devData[n*DW +: DW];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      int_q   <= '0;
      lvl_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      ack_q   <= '0;
      resp_q  <= '0;
      busy_q  <= 1'b0;
      svc_q   <= '0;
`ifdef INTR_SRC_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            state_q <= ISSUE;
            sel_q   <= pick;
            wr_q    <= 1'b1;
            din_q   <= data_q[pick];
            int_q   <= 4'b0001 << pick;
            lvl_q   <= pick;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          wr_q    <= 1'b0;
          state_q <= WAIT;
`ifdef INTR_SRC_TIMEOUT_EN
          cnt_q   <= TW'(TIMEOUT - 1);
`endif
        end
        WAIT: begin
          if (intr) begin
            resp_q  <= intDataOut;
            svc_q   <= svc_q + 16'd1;
            ack_q   <= 4'b0001 << sel_q;
            int_q   <= '0;
            lvl_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
`ifdef INTR_SRC_TIMEOUT_EN
          // Abandoned request: acknowledge the source but leave response and count alone.
          else if (cnt_q == '0) begin
            tmo_q   <= 1'b1;
            ack_q   <= 4'b0001 << sel_q;
            int_q   <= '0;
            lvl_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
`endif
        end
        DONE: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {int3, int2, int1, int0} = int_q;
  assign {intLvl1, intLvl0}       = lvl_q;
  assign intWrite                 = wr_q;
  assign intDataIn                = din_q;
  assign devAck                   = ack_q;
  assign devRespData              = resp_q;
  assign busy                     = busy_q;
  assign svcCount                 = svc_q;
`ifdef INTR_SRC_TIMEOUT_EN
  assign timeoutFlag              = tmo_q;
`endif

endmodule

// File: tb/tb_intr_source_ctrl.sv
// Directed bench for intr_source_ctrl: single request, priority, masking,
// re-request in ISSUE, ignored intr and asynchronous mid-service reset.
module tb_intr_source_ctrl;
  localparam int DW = 16;

  logic            CLK = 1'b0;
  logic            Reset;
  logic [3:0]      devReq;
  logic [4*DW-1:0] devData;
  logic [3:0]      devMask;
  logic            intr;
  logic [DW-1:0]   intDataOut;
  logic            int0, int1, int2, int3, intLvl1, intLvl0, intWrite, busy;
  logic [DW-1:0]   intDataIn, devRespData;
  logic [3:0]      devAck;
  logic [15:0]     svcCount;

  int n_vec = 0;
  int n_err = 0;

  intr_source_ctrl #(.DW(DW)) dut (
    .CLK(CLK), .Reset(Reset), .devReq(devReq), .devData(devData), .devMask(devMask),
    .intr(intr), .intDataOut(intDataOut), .int0(int0), .int1(int1), .int2(int2),
    .int3(int3), .intLvl1(intLvl1), .intLvl0(intLvl0), .intWrite(intWrite),
    .intDataIn(intDataIn), .devAck(devAck), .devRespData(devRespData), .busy(busy),
    .svcCount(svcCount)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ints();
    return {int3, int2, int1, int0};
  endfunction

  initial begin
    int seen;
    Reset = 1'b0; devReq = '0; devData = '0; devMask = '0; intr = 1'b0; intDataOut = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_intWrite", 32'(intWrite), 32'h0);
    chk("rst_ints", 32'(ints()), 32'h0);
    chk("rst_ack", 32'(devAck), 32'h0);
    chk("rst_svc", 32'(svcCount), 32'h0);
    chk("rst_resp", 32'(devRespData), 32'h0);
    Reset = 1'b1;
    step();

    // single request on source 0
    devMask = 4'hF; devData[0*DW +: DW] = 16'h1234; devReq = 4'b0001;
    step(); devReq = '0;
    chk("s0_idle_wr", 32'(intWrite), 32'h0);
    step();
    chk("s0_wr", 32'(intWrite), 32'h1);
    chk("s0_din", 32'(intDataIn), 32'h1234);
    chk("s0_ints", 32'(ints()), 32'h1);
    chk("s0_lvl", 32'({intLvl1, intLvl0}), 32'h0);
    chk("s0_busy", 32'(busy), 32'h1);
    step();
    chk("s0_wait_wr", 32'(intWrite), 32'h0);
    chk("s0_wait_ints", 32'(ints()), 32'h1);
    chk("s0_wait_din", 32'(intDataIn), 32'h1234);
    intr = 1'b1; intDataOut = 16'hBEEF;
    step(); intr = 1'b0;
    chk("s0_ack", 32'(devAck), 32'h1);
    chk("s0_resp", 32'(devRespData), 32'hBEEF);
    chk("s0_svc", 32'(svcCount), 32'h1);
    chk("s0_done_busy", 32'(busy), 32'h0);
    chk("s0_done_ints", 32'(ints()), 32'h0);
    step();
    chk("s0_ack_clr", 32'(devAck), 32'h0);

    // intr while idle is ignored
    intr = 1'b1; intDataOut = 16'hDEAD;
    step(); step(); intr = 1'b0;
    chk("idle_intr_ack", 32'(devAck), 32'h0);
    chk("idle_intr_svc", 32'(svcCount), 32'h1);
    chk("idle_intr_resp", 32'(devRespData), 32'hBEEF);

    // sources 3 and 1 together: 3 first
    devData[3*DW +: DW] = 16'h3333; devData[1*DW +: DW] = 16'h1111; devReq = 4'b1010;
    step(); devReq = '0;
    step();
    chk("pr3_ints", 32'(ints()), 32'h8);
    chk("pr3_lvl", 32'({intLvl1, intLvl0}), 32'h3);
    chk("pr3_din", 32'(intDataIn), 32'h3333);
    step();
    intr = 1'b1; intDataOut = 16'hA5A5;
    step(); intr = 1'b0;
    chk("pr3_ack", 32'(devAck), 32'h8);
    chk("pr3_svc", 32'(svcCount), 32'h2);
    step();
    step();
    chk("pr1_wr", 32'(intWrite), 32'h1);
    chk("pr1_lvl", 32'({intLvl1, intLvl0}), 32'h1);
    chk("pr1_din", 32'(intDataIn), 32'h1111);
    step();
    intr = 1'b1; intDataOut = 16'h5A5A;
    step(); intr = 1'b0;
    chk("pr1_ack", 32'(devAck), 32'h2);
    chk("pr1_svc", 32'(svcCount), 32'h3);
    chk("pr1_resp", 32'(devRespData), 32'h5A5A);
    step();

    // masked source 0 is never latched
    devMask = 4'b1110; devReq = 4'b0001;
    step(); devReq = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (intWrite || busy) seen++;
      step();
    end
    chk("mask_no_grant", 32'(seen), 32'h0);
    devMask = 4'hF;
    step(); step(); step();
    chk("mask_unmask_busy", 32'(busy), 32'h0);

    // re-request of source 2 during its ISSUE cycle
    devData[2*DW +: DW] = 16'h2222; devReq = 4'b0100;
    step(); devReq = '0;
    step();
    chk("rr_wr", 32'(intWrite), 32'h1);
    chk("rr_lvl", 32'({intLvl1, intLvl0}), 32'h2);
    devData[2*DW +: DW] = 16'h2BBB; devReq = 4'b0100;
    step(); devReq = '0;
    chk("rr_wait_din", 32'(intDataIn), 32'h2222);
    intr = 1'b1; intDataOut = 16'h0001;
    step(); intr = 1'b0;
    chk("rr_ack1", 32'(devAck), 32'h4);
    chk("rr_svc1", 32'(svcCount), 32'h4);
    step();
    step();
    chk("rr2_wr", 32'(intWrite), 32'h1);
    chk("rr2_ints", 32'(ints()), 32'h4);
    chk("rr2_din", 32'(intDataIn), 32'h2BBB);
    step();
    intr = 1'b1; intDataOut = 16'h0002;
    step(); intr = 1'b0;
    chk("rr_ack2", 32'(devAck), 32'h4);
    chk("rr_svc2", 32'(svcCount), 32'h5);
    chk("rr_resp2", 32'(devRespData), 32'h0002);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (intWrite) seen++;
    end
    chk("rr_no_third", 32'(seen), 32'h0);

    // asynchronous reset while waiting on intr
    devData[0*DW +: DW] = 16'h7777; devReq = 4'b0001;
    step(); devReq = '0;
    step(); step();
    chk("mr_wait_busy", 32'(busy), 32'h1);
    #2 Reset = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_ints", 32'(ints()), 32'h0);
    chk("mr_svc", 32'(svcCount), 32'h0);
    chk("mr_resp", 32'(devRespData), 32'h0);
    #4 Reset = 1'b1;
    step();
    intr = 1'b1; intDataOut = 16'h9999;
    step(); intr = 1'b0;
    chk("mr_no_ack", 32'(devAck), 32'h0);
    step();
    chk("mr_idle_busy", 32'(busy), 32'h0);
    chk("mr_idle_svc", 32'(svcCount), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intr_source_ctrl.md
Name: intr_source_ctrl

Overview:
- Device-side interrupt controller that drives the datapath's interrupt input interface: int0..int3, intLvl1/intLvl0, intWrite and intDataIn.
- Latches requests from four peripheral sources and arbitrates them by fixed priority.
- Presents one request at a time to the processor, then waits for the datapath's intr completion pulse.
- Returns the datapath's intDataOut to the serviced device.
- Sits between the peripheral bus and the datapath at top level.

Parameters:
- DW, 16, width of the interrupt data words (intDataIn/intDataOut).
- TIMEOUT, 1024, cycles to wait for intr before abandoning a request (used only with the optional feature).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- devReq  input  4  per-source request pulse/level; bit n = source n.
- devData  input  4*DW  per-source payload; source n occupies bits [n*DW +: DW].
- devMask  input  4  1 = source enabled; masked sources are never latched.
- intr  input  1  datapath completion pulse for the in-service interrupt.
- intDataOut  input  DW  datapath response word, valid while intr=1.
- int0, int1, int2, int3  output  1 each  one-hot in-service line to datapath.
- intLvl1, intLvl0  output  1 each  encoded index of the in-service source.
- intWrite  output  1  single-cycle strobe qualifying intDataIn.
- intDataIn  output  DW  payload of the in-service source.
- devAck  output  4  single-cycle completion pulse to source n.
- devRespData  output  DW  captured intDataOut, held until the next completion.
- busy  output  1  1 while a request is in service.
- svcCount  output  16  number of completed services; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (Reset=0, asynchronous) clears everything: pending=0, state=IDLE, int0..3=0, intLvl=00, intWrite=0, intDataIn=0, devAck=0, devRespData=0, busy=0, svcCount=0.
- Pending latch:
  - pending[n] is set on any clock with devReq[n]=1 and devMask[n]=1.
  - The source payload is captured into dataReg[n] at the same time.
  - A re-request while pending overwrites dataReg[n] (last wins); no duplicate is queued.
  - Masking a pending source does not clear it.
- Priority: source 3 is highest, source 0 lowest; fixed, no rotation.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any pending bit is set, select the highest index n, go to ISSUE next cycle. Grant latency from the request edge to intWrite is 2 cycles.
  - ISSUE (1 cycle):
    - intWrite=1, intDataIn=dataReg[n], int_n=1, {intLvl1,intLvl0}=n, busy=1.
    - pending[n] cleared this cycle.
    - Go to WAIT.
  - WAIT:
    - int_n, intLvl and intDataIn are held stable; intWrite=0.
    - On intr=1: devRespData<=intDataOut, go to DONE.
  - DONE (1 cycle):
    - devAck[n]=1, svcCount+=1, int lines drop to 0, busy=0.
    - Go to IDLE. A new grant may issue on the following cycle.
- Simultaneous events:
  - A new devReq[n] in the same cycle ISSUE clears pending[n]: set wins, so the source is re-served later.
  - Requests arriving during WAIT are latched and served after DONE; there is no preemption.
  - intr while IDLE/ISSUE/DONE is ignored.
- int0..int3 are always one-hot or all-zero.
- Reset mid-service aborts immediately: no devAck is issued and the pending request is lost.

Optional Feature:
- Macro INTR_SRC_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - If intr has not arrived after TIMEOUT cycles, go to DONE without capturing intDataOut. devRespData is unchanged, devAck[n] still pulses, and svcCount is not incremented.
  - An extra output timeoutFlag (1 bit) is set and sticky until reset.
- When undefined: WAIT holds indefinitely, and no counter or timeoutFlag port exists.

Test Plan:
- Single request: devMask=4'hF, devReq=0001 one cycle, devData[0]=0x1234.
  - intWrite pulses 2 cycles later with intDataIn=0x1234, int0=1, intLvl=00.
  - Drive intr=1 with intDataOut=0xBEEF: devAck=0001 next cycle, devRespData=0xBEEF, svcCount=1.
- Priority: devReq=1010 same cycle.
  - Source 3 issued first (int3=1, intLvl=11).
  - After its intr, source 1 issued (intLvl=01).
  - svcCount=2 at the end.
- Masking: devMask=1110, devReq=0001 -> no intWrite for 20 cycles, busy=0.
- Mid-service reset: in WAIT, pulse Reset=0 for 5 ns -> all outputs 0 immediately; a later intr produces no devAck.
- Re-request during ISSUE: devReq[2] asserted in the ISSUE cycle of source 2 -> source 2 is served twice in total, svcCount=2.
- INTR_SRC_TIMEOUT_EN with TIMEOUT=8: request source 0, never drive intr -> devAck[0] pulses 8 cycles after entering WAIT, timeoutFlag=1, svcCount=0.
